// File: rtl/icache_fetch_if.sv
// Fetch-stage and memory-controller signal bundle for icache_fetch.
// The slave modport is the cache; master is the environment (fetch stage plus memory controller).
interface icache_fetch_if;
    logic        start_fetch;
    logic        rob_clear;
    logic [31:0] pc;
    logic        instr_ready;
    logic [31:0] instr;
    logic [31:0] instr_addr;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic        mem_done;
    logic [31:0] mem_data;

    modport slave (
        input  start_fetch, rob_clear, pc, mem_done, mem_data,
        output instr_ready, instr, instr_addr, mem_req, mem_addr
    );

    modport master (
        output start_fetch, rob_clear, pc, mem_done, mem_data,
        input  instr_ready, instr, instr_addr, mem_req, mem_addr
    );
endinterface

// File: rtl/icache_fetch.sv
// Direct-mapped instruction cache with word-by-word line refill.
// Optional hit/miss counters are enabled by defining ICACHE_STATS_EN.
module icache_fetch #(
    parameter int INDEX_BITS = 6,
    parameter int WORD_BITS  = 2
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               rdy,
    icache_fetch_if.slave      bus
`ifdef ICACHE_STATS_EN
    ,
    output logic [31:0]        hit_count,
    output logic [31:0]        miss_count
`endif
);

    localparam int LINES    = 1 << INDEX_BITS;
    localparam int WORDS    = 1 << WORD_BITS;
    localparam int TAG_LSB  = INDEX_BITS + WORD_BITS + 2;
    localparam int TAG_BITS = 32 - TAG_LSB;
    localparam int RA_BITS  = INDEX_BITS + WORD_BITS;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_REFILL = 2'd1;
    localparam logic [1:0] ST_COOL   = 2'd2;

    logic [31:0]         data_mem [LINES*WORDS];
    logic [TAG_BITS-1:0] tag_mem  [LINES];
    logic [LINES-1:0]    valid_q, valid_d;

    logic [1:0]  state_q, state_d;
    logic        instr_ready_q, instr_ready_d;
    logic [31:0] instr_q, instr_d;
    logic [31:0] instr_addr_q, instr_addr_d;
    logic        mem_req_q, mem_req_d;
    logic [31:0] mem_addr_q, mem_addr_d;
    logic [31:0] pc_lat_q, pc_lat_d;
    logic        drop_q, drop_d;

    logic        wr_en;
    logic        install;
    logic        lookup_hit;
    logic        miss_start;

    // Lookup side: address fields of the incoming pc
    logic [INDEX_BITS-1:0] pc_index;
    logic [TAG_BITS-1:0]   pc_tag;
    logic [RA_BITS-1:0]    lookup_ra;
    logic [31:0]           lookup_data;

    assign pc_index    = bus.pc[TAG_LSB-1:WORD_BITS+2];
    assign pc_tag      = bus.pc[31:TAG_LSB];
    assign lookup_ra   = bus.pc[TAG_LSB-1:2];
    assign lookup_data = data_mem[lookup_ra];
    assign lookup_hit  = valid_q[pc_index] && (tag_mem[pc_index] == pc_tag);

    // Refill side: the word currently being fetched and the word owed to the fetch stage
    logic [INDEX_BITS-1:0] fill_index;
    logic [WORD_BITS-1:0]  fill_word;
    logic [TAG_BITS-1:0]   fill_tag;
    logic [RA_BITS-1:0]    fill_ra;
    logic [RA_BITS-1:0]    pend_ra;
    logic [31:0]           pend_data;
    logic                  fill_last;

    assign fill_index = mem_addr_q[TAG_LSB-1:WORD_BITS+2];
    assign fill_word  = mem_addr_q[WORD_BITS+1:2];
    assign fill_tag   = mem_addr_q[31:TAG_LSB];
    assign fill_ra    = mem_addr_q[TAG_LSB-1:2];
    assign fill_last  = &fill_word;
    assign pend_ra    = pc_lat_q[TAG_LSB-1:2];
    // The requested word may be the one arriving this very cycle
    assign pend_data  = (wr_en && (pend_ra == fill_ra)) ? bus.mem_data : data_mem[pend_ra];

    always_comb begin
        state_d       = state_q;
        instr_ready_d = 1'b0;
        instr_d       = instr_q;
        instr_addr_d  = instr_addr_q;
        mem_req_d     = mem_req_q;
        mem_addr_d    = mem_addr_q;
        pc_lat_d      = pc_lat_q;
        drop_d        = drop_q;
        wr_en         = 1'b0;
        install       = 1'b0;
        miss_start    = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (bus.start_fetch && !bus.rob_clear) begin
                    if (lookup_hit) begin
                        instr_ready_d = 1'b1;
                        instr_d       = lookup_data;
                        instr_addr_d  = bus.pc;
                        state_d       = ST_COOL;
                    end else begin
                        miss_start = 1'b1;
                        pc_lat_d   = bus.pc;
                        mem_addr_d = {bus.pc[31:WORD_BITS+2], {(WORD_BITS+2){1'b0}}};
                        mem_req_d  = 1'b1;
                        drop_d     = 1'b0;
                        state_d    = ST_REFILL;
                    end
                end
            end
            ST_REFILL: begin
                if (bus.rob_clear) begin
                    drop_d = 1'b1;
                end
                if (bus.mem_done && mem_req_q) begin
                    wr_en      = 1'b1;
                    mem_addr_d = mem_addr_q + 32'd4;
                    if (fill_last) begin
                        install   = 1'b1;
                        mem_req_d = 1'b0;
                        if (drop_q || bus.rob_clear) begin
                            state_d = ST_IDLE;
                        end else begin
                            instr_ready_d = 1'b1;
                            instr_d       = pend_data;
                            instr_addr_d  = pc_lat_q;
                            state_d       = ST_COOL;
                        end
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // One valid bit per line; a completed refill sets its line's bit
    for (genvar gi = 0; gi < LINES; gi++) begin : g_valid
        assign valid_d[gi] = valid_q[gi] | (install && (fill_index == INDEX_BITS'(gi)));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= ST_IDLE;
            instr_ready_q <= 1'b0;
            instr_q       <= 32'd0;
            instr_addr_q  <= 32'd0;
            mem_req_q     <= 1'b0;
            mem_addr_q    <= 32'd0;
            pc_lat_q      <= 32'd0;
            drop_q        <= 1'b0;
            valid_q       <= '0;
        end else if (rdy) begin
            state_q       <= state_d;
            instr_ready_q <= instr_ready_d;
            instr_q       <= instr_d;
            instr_addr_q  <= instr_addr_d;
            mem_req_q     <= mem_req_d;
            mem_addr_q    <= mem_addr_d;
            pc_lat_q      <= pc_lat_d;
            drop_q        <= drop_d;
            valid_q       <= valid_d;
        end
    end

    // Arrays carry no reset; the valid bits alone decide whether contents are meaningful
    always_ff @(posedge clk) begin
        if (!rst && rdy) begin
            if (wr_en) begin
                data_mem[fill_ra] <= bus.mem_data;
            end
            if (install) begin
                tag_mem[fill_index] <= fill_tag;
            end
        end
    end

    assign bus.instr_ready = instr_ready_q;
    assign bus.instr       = instr_q;
    assign bus.instr_addr  = instr_addr_q;
    assign bus.mem_req     = mem_req_q;
    assign bus.mem_addr    = mem_addr_q;

`ifdef ICACHE_STATS_EN
    logic [31:0] hit_count_q, hit_count_d;
    logic [31:0] miss_count_q, miss_count_d;

    always_comb begin
        hit_count_d  = hit_count_q;
        miss_count_d = miss_count_q;
        if (state_q == ST_IDLE && bus.start_fetch && !bus.rob_clear && lookup_hit) begin
            hit_count_d = hit_count_q + 32'd1;
        end
        if (miss_start) begin
            miss_count_d = miss_count_q + 32'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            hit_count_q  <= 32'd0;
            miss_count_q <= 32'd0;
        end else if (rdy) begin
            hit_count_q  <= hit_count_d;
            miss_count_q <= miss_count_d;
        end
    end

    assign hit_count  = hit_count_q;
    assign miss_count = miss_count_q;
`endif

endmodule

// File: doc/icache_fetch.md
Name: icache_fetch

Overview:
- Direct-mapped instruction cache between the memory controller and the fetch stage.
- Accepts one word-fetch request at a time from the fetch stage (start_fetch/pc).
- Returns a one-cycle instr_ready pulse with the instruction word and its address.
- On a miss, refills a whole line word-by-word through a request/done handshake to the memory controller.

Parameters:
INDEX_BITS, 6, log2 of line count (64 lines)
WORD_BITS, 2, log2 of words per line (4 words = 16 B)

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
rdy  in  1  global ready; when 0 all state holds
rob_clear  in  1  pipeline flush
start_fetch  in  1  fetch request valid, held until served
pc  in  32  fetch address, word-aligned
instr_ready  out  1  one-cycle pulse: instruction valid
instr  out  32  instruction word
instr_addr  out  32  address of delivered instruction
mem_req  out  1  refill word request
mem_addr  out  32  refill word address, word-aligned
mem_done  in  1  one-cycle pulse: mem_data valid for mem_addr
mem_data  in  32  refill word

Behaviour:
- Clock, reset, stall
  - All state updates occur on posedge clk.
  - rst has priority; rdy=0 freezes every register, including outputs.
  - Reset values: instr_ready=0, instr=0, instr_addr=0, mem_req=0, mem_addr=0, every valid bit=0, state=IDLE.
- Address split
  - [1:0] is ignored.
  - word = [WORD_BITS+1:2]
  - index = [INDEX_BITS+WORD_BITS+1:WORD_BITS+2]
  - tag = remaining upper bits.
- Storage: per line a valid bit, a tag, and 2^WORD_BITS data words.
- States: IDLE, REFILL, COOL.
- IDLE
  - If start_fetch && !rob_clear and the lookup hits: next cycle instr_ready=1, instr=word, instr_addr=pc; go to COOL. Hit latency is 1 cycle.
  - On a miss: latch pc, mem_addr={pc[31:WORD_BITS+2], WORD_BITS'b0, 2'b00}, mem_req=1; go to REFILL.
- REFILL
  - mem_req stays high with mem_addr stable until mem_done.
  - On mem_done: write mem_data into line word (mem_addr word field) and advance mem_addr by 4.
  - On the last word's mem_done:
    - mem_req=0, set valid and tag.
    - If no flush is pending: next cycle instr_ready=1 with the latched pc's word; go to COOL.
  - Words fill from word 0 upward. No critical-word-first.
- COOL
  - One cycle with instr_ready=0 and requests ignored, then go to IDLE.
  - This guarantees the fetch stage has dropped start_fetch before the next lookup, so there is no duplicate delivery.
- instr_ready is high for exactly one cycle per served request. instr/instr_addr are undefined when instr_ready=0.
- rob_clear
  - In IDLE/COOL: instr_ready=0 that cycle; go to IDLE; no lookup.
  - In REFILL: set a drop flag. The refill completes and installs the line (memory transactions are never aborted), but nothing is delivered; return to IDLE.
  - rob_clear on the same cycle as the final mem_done also suppresses delivery.
- Conflict: a miss overwrites the indexed line unconditionally. There is no write path (self-modifying code unsupported).
- mem_done while mem_req=0 is ignored.

Optional Feature:
- Macro ICACHE_STATS_EN.
- When defined:
  - Adds outputs hit_count[31:0] and miss_count[31:0], reset to 0, wrapping at 2^32.
  - hit_count increments once per IDLE hit; miss_count increments once per REFILL entry.
  - Both freeze when rdy=0.
- When undefined: ports and counters are absent; behaviour is otherwise identical.

Test Plan:
- Cold miss at pc=0x0000_0000
  - Stimulus: memory returns 0x11,0x22,0x33,0x44 with 2-cycle mem_done latency each.
  - Required: mem_addr sequence 0x0,0x4,0x8,0xC, then instr_ready pulse with instr=0x11, instr_addr=0x0.
- Hit after fill
  - Stimulus: request pc=0x8.
  - Required: instr_ready exactly 1 cycle after start_fetch, instr=0x33, mem_req never asserted.
- Conflict (default params)
  - Stimulus: request pc=0x400 (same index 0, new tag), then pc=0x0.
  - Required: both refill; second request shows mem_req again, proving eviction.
- Flush mid-refill
  - Stimulus: assert rob_clear after 2nd mem_done of a miss at 0x20.
  - Required: remaining two words still requested, no instr_ready. A later pc=0x24 hits in 1 cycle.
- rdy stall
  - Stimulus: drop rdy for 5 cycles while a hit result is pending.
  - Required: instr_ready asserts only after rdy returns, still exactly one cycle wide; mem_addr unchanged during stall.
- Reset mid-refill
  - Stimulus: assert rst during REFILL.
  - Required: next cycle mem_req=0, instr_ready=0; pc=0x0 then misses (all valid bits cleared).
